// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default oversample
// ratio, common to the RX and TX stages.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Line side and host side signals of the UART receiver.
// The slave modport is the receiver; master is its environment.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);

  logic                 rx;
  logic                 clken;
  logic                 ready_clr;
  logic [DATA_BITS-1:0] data;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 rx_busy;

  modport master (
    output rx, clken, ready_clr,
    input  data, ready, frame_err,
    input  overrun, rx_busy
  );

  modport slave (
    input  rx, clken, ready_clr,
    output data, ready, frame_err,
    output overrun, rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Metastability synchronizer for the asynchronous rx line.
// Flops reset to 1 so the line reads idle out of reset.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50mhz,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_ff;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_ff <= '1;
    end else begin
      r_ff <= {r_ff[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver driven by a 16x-baud sample strobe.
// Reports ready, frame error and overrun to the byte consumer.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk_50mhz,
  input  logic            rst,
  uart_receiver_if.slave  bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(OVERSAMPLE/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(DATA_BITS - 1);

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] w_shreg_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_ready;
  logic                 w_ready_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_ovr;
  logic                 w_ovr_nxt;
  logic                 r_rx_prev;
  logic                 w_rx_s;
  logic                 w_start;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_50mhz(clk_50mhz),
    .rst      (rst),
    .d        (bus.rx),
    .q        (w_rx_s)
  );

  // Only a true falling edge starts a frame; a stuck-low line never does.
  assign w_start = r_rx_prev & ~w_rx_s;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shreg   <= '0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
      r_rx_prev <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shreg   <= w_shreg_nxt;
      r_data    <= w_data_nxt;
      r_ready   <= w_ready_nxt;
      r_ferr    <= w_ferr_nxt;
      r_ovr     <= w_ovr_nxt;
      if (bus.clken) begin
        r_rx_prev <= w_rx_s;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_ready_nxt = r_ready;
    w_ferr_nxt  = r_ferr;
    w_ovr_nxt   = r_ovr;
    if (bus.ready_clr) begin
      w_ready_nxt = 1'b0;
      w_ovr_nxt   = 1'b0;
    end
    if (bus.clken) begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            w_state_nxt = START;
            w_cnt_nxt   = '0;
          end
        end
        START: begin
          if (r_cnt == HALF_M1) begin
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            w_state_nxt = w_rx_s ? IDLE : DATA;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == FULL_M1) begin
            w_shreg_nxt = {w_rx_s, r_shreg[DATA_BITS-1:1]};
            w_cnt_nxt   = '0;
            if (r_idx == LAST_IX) begin
              w_state_nxt = STOP;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == FULL_M1) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            // A commit beats a same-cycle ack; the ack consumed the old byte.
            if (w_rx_s) begin
              w_data_nxt  = r_shreg;
              w_ready_nxt = 1'b1;
              w_ferr_nxt  = 1'b0;
              w_ovr_nxt   = (r_ready | r_ovr) & ~bus.ready_clr;
            end else begin
              w_ferr_nxt  = 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.ready     = r_ready;
  assign bus.frame_err = r_ferr;
  assign bus.overrun   = r_ovr;
  assign bus.rx_busy   = (r_state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed table, corner
// sequences and random frames against a byte-level reference model.
module tb_uart_receiver;

  localparam int OS = 16;

  logic clk;
  logic rst;

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver dut (
    .clk_50mhz(clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic       ack;
    int         div;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_ferr;
    logic       e_ovr;
  } vec_t;

  vec_t tbl [6];

  logic [7:0] m_data;
  logic       m_rdy;
  logic       m_ferr;
  logic       m_ovr;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic ce);
    bus.clken = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int strobes, input int div);
    for (int s = 0; s < strobes; s++)
      for (int p = 0; p < div; p++) step(p == div - 1);
  endtask

  task automatic do_reset();
    bus.rx = 1'b1;
    bus.clken = 1'b0;
    bus.ready_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4, 1);
  endtask

  task automatic ack_pulse();
    bus.ready_clr = 1'b1;
    step(1'b0);
    bus.ready_clr = 1'b0;
  endtask

  // Serialises one 8N1 frame; ack_at is the posedge index (from the
  // start-bit drive) before which ready_clr is held high, 0 for none.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int div, input int ack_at,
                            output int first_rdy);
    int n;
    logic [9:0] fr;
    n = 0;
    first_rdy = 0;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = fr[i];
      for (int s = 0; s < OS; s++) begin
        for (int p = 0; p < div; p++) begin
          bus.ready_clr = (n + 1 == ack_at);
          step(p == div - 1);
          n++;
          if (bus.ready && first_rdy == 0) first_rdy = n;
        end
      end
    end
    bus.ready_clr = 1'b0;
    bus.rx = 1'b1;
    idle(4, div);
  endtask

  task automatic chk_out(input string nm, input logic [7:0] d,
                         input logic r, input logic f, input logic o);
    chk({nm, ".data"}, 32'(bus.data), 32'(d));
    chk({nm, ".ready"}, 32'(bus.ready), 32'(r));
    chk({nm, ".frame_err"}, 32'(bus.frame_err), 32'(f));
    chk({nm, ".overrun"}, 32'(bus.overrun), 32'(o));
  endtask

  initial begin
    int fr_r;
    int busy;
    int exp_lat;
    logic [7:0] rb;
    logic rs;
    logic ra;
    int rd;

    tbl[0] = '{8'h55, 1'b1, 1'b0, 1, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'hA3, 1'b0, 1'b0, 2, 8'h55, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h34, 1'b1, 1'b0, 1, 8'h34, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1'b1, 1'b1, 3, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h81, 1'b1, 1'b0, 4, 8'h81, 1'b1, 1'b0, 1'b0};

    do_reset();
    chk_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("reset.rx_busy", 32'(bus.rx_busy), 0);

    // False start: low for 4 clocks, then idle.
    busy = 0;
    bus.rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) bus.rx = 1'b1;
      step(1'b1);
      if (bus.rx_busy) busy++;
    end
    chk("false_start.busy_strobes", 32'(busy), OS / 2);
    chk("false_start.ready", 32'(bus.ready), 0);
    chk("false_start.frame_err", 32'(bus.frame_err), 0);
    chk("false_start.rx_busy", 32'(bus.rx_busy), 0);

    // Latency from start edge to ready with clken held high.
    exp_lat = 1 + 2 + 9 * OS + OS / 2;
    send_frame(8'h55, 1'b1, 1, 0, fr_r);
    chk("latency", 32'(fr_r), 32'(exp_lat));
    chk_out("frame55", 8'h55, 1'b1, 1'b0, 1'b0);

    do_reset();
    foreach (tbl[k]) begin
      if (tbl[k].ack) ack_pulse();
      send_frame(tbl[k].b, tbl[k].stop, tbl[k].div, 0, fr_r);
      chk_out($sformatf("tbl%0d", k), tbl[k].e_data, tbl[k].e_rdy,
              tbl[k].e_ferr, tbl[k].e_ovr);
    end

    // Overrun then explicit acknowledge.
    send_frame(8'h12, 1'b1, 1, 0, fr_r);
    chk_out("ovr12", 8'h12, 1'b1, 1'b0, 1'b1);
    ack_pulse();
    chk_out("ack", 8'h12, 1'b0, 1'b0, 1'b0);

    // Acknowledge on the exact commit edge: set wins, overrun stays 0.
    send_frame(8'h11, 1'b1, 1, 0, fr_r);
    send_frame(8'h7E, 1'b1, 1, exp_lat, fr_r);
    chk_out("ack_on_commit", 8'h7E, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of a 0xFF frame, released with rx low.
    bus.rx = 1'b0;
    idle(OS, 1);
    bus.rx = 1'b1;
    idle(40, 1);
    bus.rx = 1'b0;
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    chk_out("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_reset.rx_busy", 32'(bus.rx_busy), 0);
    rst = 1'b0;
    busy = 0;
    for (int s = 0; s < 3 * OS; s++)
      for (int p = 0; p < 4; p++) begin
        step(p == 3);
        if (bus.rx_busy || bus.ready) busy++;
      end
    chk("stuck_low.activity", 32'(busy), 0);
    bus.rx = 1'b1;
    idle(OS, 4);
    chk("pre_c4.ready", 32'(bus.ready), 0);
    send_frame(8'hC4, 1'b1, 4, 0, fr_r);
    chk_out("c4_div4", 8'hC4, 1'b1, 1'b0, 1'b0);

    // Random frames against the byte-level model.
    m_data = 8'hC4;
    m_rdy = 1'b1;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      rs = ($urandom % 4) != 0;
      ra = 1'($urandom);
      rd = 1 + int'($urandom_range(2));
      if (ra) begin
        ack_pulse();
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
      send_frame(rb, rs, rd, 0, fr_r);
      if (rs) begin
        m_ovr = m_rdy;
        m_rdy = 1'b1;
        m_data = rb;
        m_ferr = 1'b0;
      end else begin
        m_ferr = 1'b1;
      end
      chk_out($sformatf("rnd%0d", k), m_data, m_rdy, m_ferr, m_ovr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
